// File: rtl/pc_branch_unit.sv
// pc_branch_unit
//   Program counter and branch unit for the SAP-1.5 core. Handles fetch
//   increment, condition-code-selected jumps, conditional calls and
//   unconditional returns through a small hardware return-address stack.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   pc_enable           : increment request (fetch)
//   jump_req            : conditional jump request
//   call_req            : conditional call request (push return address)
//   ret_req             : return request (pop return address)
//   cond[2:0]           : condition select for jump/call
//   target              : jump/call destination
//   flag_zero/carry/negative : ALU flags, sampled on the request edge
//   counter_out         : current PC (registered)
//   taken               : one-cycle pulse after an accepted jump/call/ret
//   stack_depth_o       : return-stack occupancy
//   stack_overflow      : sticky, call attempted with stack full
//   stack_underflow     : sticky, ret attempted with stack empty
//
// Request handling: requests are level strobes sampled on the rising edge;
// there is no handshake back to the control unit. When several are high on
// one edge only the highest-priority one acts (ret > call > jump > enable),
// the rest are dropped for that cycle.
module pc_branch_unit #(
  parameter int ADDR_WIDTH  = 8,
  parameter int STACK_DEPTH = 4,
  parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pc_enable,
  input  logic                  jump_req,
  input  logic                  call_req,
  input  logic                  ret_req,
  input  logic [2:0]            cond,
  input  logic [ADDR_WIDTH-1:0] target,
  input  logic                  flag_zero,
  input  logic                  flag_carry,
  input  logic                  flag_negative,
  output logic [ADDR_WIDTH-1:0] counter_out,
  output logic                  taken,
  output logic [DEPTH_W-1:0]    stack_depth_o,
  output logic                  stack_overflow,
  output logic                  stack_underflow
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  taken_q, taken_d;
  logic [DEPTH_W-1:0]    depth_q, depth_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];

  logic                  cond_true;
  logic                  stack_full;
  logic                  stack_empty;
  logic                  push;
  logic [ADDR_WIDTH-1:0] top_entry;

  // Condition-code decode.
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'b000: cond_true = 1'b1;
      3'b001: cond_true = flag_zero;
      3'b010: cond_true = ~flag_zero;
      3'b011: cond_true = flag_carry;
      3'b100: cond_true = ~flag_carry;
      3'b101: cond_true = flag_negative;
      3'b110: cond_true = ~flag_negative;
      default: cond_true = 1'b0;
    endcase
  end

  assign stack_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign stack_empty = (depth_q == '0);

  // Top-of-stack is entry depth-1. Selected by compare rather than by
  // indexing so STACK_DEPTH=1 needs no zero-width index.
  always_comb begin
    top_entry = stack_q[0];
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (depth_q == DEPTH_W'(i + 1)) top_entry = stack_q[i];
    end
  end

  // Next-state logic with fixed priority ret > call > jump > increment.
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    taken_d = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (ret_req) begin
      if (!stack_empty) begin
        pc_d    = top_entry;
        depth_d = depth_q - DEPTH_W'(1);
        taken_d = 1'b1;
      end else begin
        unf_d = 1'b1;
      end
    end else if (call_req) begin
      if (cond_true) begin
        if (!stack_full) begin
          push    = 1'b1;
          pc_d    = target;
          depth_d = depth_q + DEPTH_W'(1);
          taken_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end else if (jump_req) begin
      // A failed jump leaves the PC alone: fetch already stepped past the operand.
      if (cond_true) begin
        pc_d    = target;
        taken_d = 1'b1;
      end
    end else if (pc_enable) begin
      pc_d = pc_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      taken_q <= 1'b0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      taken_q <= taken_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage is not reset; depth alone says which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (!reset && push && depth_q == DEPTH_W'(i)) stack_q[i] <= pc_q;
    end
  end

  assign counter_out     = pc_q;
  assign taken           = taken_q;
  assign stack_depth_o   = depth_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
module tb_pc_branch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       pc_enable, jump_req, call_req, ret_req;
  logic [2:0] cond;
  logic [7:0] target;
  logic [3:0] target4;
  logic       flag_zero, flag_carry, flag_negative;

  logic [7:0] counter_out;
  logic       taken;
  logic [2:0] stack_depth_o;
  logic       stack_overflow, stack_underflow;

  logic [3:0] counter_out4;
  logic       taken4;
  logic [2:0] stack_depth_o4;
  logic       stack_overflow4, stack_underflow4;

  int total = 0;
  int bad   = 0;

  assign target4 = target[3:0];

  // clock / reset block
  always #5 clk = ~clk;

  pc_branch_unit #(.ADDR_WIDTH(8), .STACK_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .pc_enable(pc_enable), .jump_req(jump_req),
    .call_req(call_req), .ret_req(ret_req), .cond(cond), .target(target),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_negative(flag_negative),
    .counter_out(counter_out), .taken(taken), .stack_depth_o(stack_depth_o),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  pc_branch_unit #(.ADDR_WIDTH(4), .STACK_DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .pc_enable(pc_enable), .jump_req(jump_req),
    .call_req(call_req), .ret_req(ret_req), .cond(cond), .target(target4),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_negative(flag_negative),
    .counter_out(counter_out4), .taken(taken4), .stack_depth_o(stack_depth_o4),
    .stack_overflow(stack_overflow4), .stack_underflow(stack_underflow4)
  );

  // driver tasks: set strobes, wait one edge, settle, clear strobes
  task automatic idle_inputs();
    reset = 1'b0; pc_enable = 1'b0; jump_req = 1'b0; call_req = 1'b0; ret_req = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    reset = 1'b1; step();
  endtask

  task automatic do_inc();
    pc_enable = 1'b1; step();
  endtask

  task automatic do_jump(input logic [2:0] c, input logic [7:0] t);
    jump_req = 1'b1; cond = c; target = t; step();
  endtask

  task automatic do_call(input logic [2:0] c, input logic [7:0] t);
    call_req = 1'b1; cond = c; target = t; step();
  endtask

  task automatic do_ret();
    ret_req = 1'b1; step();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (counter_out !== 8'h00) begin bad++; $display("FAIL reset_pc got=%h exp=00", counter_out); end
    total++; if (taken !== 1'b0) begin bad++; $display("FAIL reset_taken got=%b exp=0", taken); end
    total++; if (stack_depth_o !== 3'd0) begin bad++; $display("FAIL reset_depth got=%0d exp=0", stack_depth_o); end
    total++; if (stack_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", stack_overflow); end
    total++; if (stack_underflow !== 1'b0) begin bad++; $display("FAIL reset_unf got=%b exp=0", stack_underflow); end
  endtask

  task automatic test_increment();
    logic [7:0] exp_pc [3] = '{8'h01, 8'h02, 8'h03};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_inc();
      total++; if (counter_out !== exp_pc[i]) begin bad++; $display("FAIL inc_pc[%0d] got=%h exp=%h", i, counter_out, exp_pc[i]); end
      total++; if (taken !== 1'b0) begin bad++; $display("FAIL inc_taken[%0d] got=%b exp=0", i, taken); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    do_jump(3'b000, 8'h0F);
    total++; if (counter_out4 !== 4'hF) begin bad++; $display("FAIL wrap4_setup got=%h exp=f", counter_out4); end
    do_inc();
    total++; if (counter_out4 !== 4'h0) begin bad++; $display("FAIL wrap4 got=%h exp=0", counter_out4); end
    total++; if (counter_out !== 8'h10) begin bad++; $display("FAIL inc8_carry got=%h exp=10", counter_out); end
    do_jump(3'b000, 8'hFF);
    do_inc();
    total++; if (counter_out !== 8'h00) begin bad++; $display("FAIL wrap8 got=%h exp=00", counter_out); end
  endtask

  task automatic test_jump_carry();
    do_reset();
    flag_zero = 1'b0; flag_carry = 1'b0; flag_negative = 1'b0;
    do_jump(3'b000, 8'h05);
    flag_carry = 1'b1;
    do_jump(3'b011, 8'h06);
    total++; if (counter_out !== 8'h06) begin bad++; $display("FAIL jc_taken_pc got=%h exp=06", counter_out); end
    total++; if (taken !== 1'b1) begin bad++; $display("FAIL jc_taken_pulse got=%b exp=1", taken); end
    step();
    total++; if (taken !== 1'b0) begin bad++; $display("FAIL jc_pulse_end got=%b exp=0", taken); end
    do_jump(3'b000, 8'h07);
    flag_carry = 1'b0;
    do_jump(3'b011, 8'h0A);
    total++; if (counter_out !== 8'h07) begin bad++; $display("FAIL jc_not_taken_pc got=%h exp=07", counter_out); end
    total++; if (taken !== 1'b0) begin bad++; $display("FAIL jc_not_taken_pulse got=%b exp=0", taken); end
  endtask

  // Hand-derived decode table, index {cond,f}. The flag a code tests is set
  // to f and the other two to ~f so a wrong flag selection shows up.
  task automatic test_cond_sweep();
    logic [15:0] exp_taken_tbl;
    logic        e;
    logic [7:0]  exp_pc;
    //               c7  c6  c5  c4  c3  c2  c1  c0   (each pair f1,f0)
    exp_taken_tbl = 16'b00_01_10_01_10_01_10_11;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 2; f++) begin
        do_jump(3'b000, 8'h10);
        flag_zero     = (c == 1 || c == 2 || c == 0 || c == 7) ? f[0] : ~f[0];
        flag_carry    = (c == 3 || c == 4 || c == 0 || c == 7) ? f[0] : ~f[0];
        flag_negative = (c == 5 || c == 6 || c == 0 || c == 7) ? f[0] : ~f[0];
        do_jump(c[2:0], 8'h40);
        e = exp_taken_tbl[c * 2 + f];
        exp_pc = e ? 8'h40 : 8'h10;
        total++; if (counter_out !== exp_pc) begin bad++; $display("FAIL sweep_pc c=%0d f=%0d got=%h exp=%h", c, f, counter_out, exp_pc); end
        total++; if (taken !== e) begin bad++; $display("FAIL sweep_taken c=%0d f=%0d got=%b exp=%b", c, f, taken, e); end
      end
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    do_jump(3'b000, 8'h12);
    do_call(3'b000, 8'h80);
    total++; if (counter_out !== 8'h80) begin bad++; $display("FAIL call_pc got=%h exp=80", counter_out); end
    total++; if (stack_depth_o !== 3'd1) begin bad++; $display("FAIL call_depth got=%0d exp=1", stack_depth_o); end
    total++; if (taken !== 1'b1) begin bad++; $display("FAIL call_taken got=%b exp=1", taken); end
    do_inc(); do_inc();
    total++; if (counter_out !== 8'h82) begin bad++; $display("FAIL call_inc got=%h exp=82", counter_out); end
    flag_zero = 1'b0;
    do_call(3'b001, 8'hA0);
    total++; if (counter_out !== 8'h82) begin bad++; $display("FAIL call_false_pc got=%h exp=82", counter_out); end
    total++; if (stack_depth_o !== 3'd1) begin bad++; $display("FAIL call_false_depth got=%0d exp=1", stack_depth_o); end
    total++; if (taken !== 1'b0) begin bad++; $display("FAIL call_false_taken got=%b exp=0", taken); end
    do_ret();
    total++; if (counter_out !== 8'h12) begin bad++; $display("FAIL ret_pc got=%h exp=12", counter_out); end
    total++; if (stack_depth_o !== 3'd0) begin bad++; $display("FAIL ret_depth got=%0d exp=0", stack_depth_o); end
    total++; if (taken !== 1'b1) begin bad++; $display("FAIL ret_taken got=%b exp=1", taken); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_jump(3'b000, 8'h21);
    do_call(3'b000, 8'h90);
    total++; if (taken !== 1'b1) begin bad++; $display("FAIL b2b_call_taken got=%b exp=1", taken); end
    do_ret();
    total++; if (counter_out !== 8'h21) begin bad++; $display("FAIL b2b_ret_pc got=%h exp=21", counter_out); end
    total++; if (taken !== 1'b1) begin bad++; $display("FAIL b2b_ret_taken got=%b exp=1", taken); end
  endtask

  task automatic test_overflow_underflow();
    logic [7:0] exp_ret [4] = '{8'h50, 8'h40, 8'h30, 8'h20};
    do_reset();
    do_jump(3'b000, 8'h20);
    do_call(3'b000, 8'h30);
    do_call(3'b000, 8'h40);
    do_call(3'b000, 8'h50);
    do_call(3'b000, 8'h60);
    total++; if (stack_depth_o !== 3'd4) begin bad++; $display("FAIL ovf_fill_depth got=%0d exp=4", stack_depth_o); end
    total++; if (stack_overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", stack_overflow); end
    do_call(3'b000, 8'h70);
    total++; if (counter_out !== 8'h60) begin bad++; $display("FAIL ovf_pc got=%h exp=60", counter_out); end
    total++; if (stack_depth_o !== 3'd4) begin bad++; $display("FAIL ovf_depth got=%0d exp=4", stack_depth_o); end
    total++; if (stack_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", stack_overflow); end
    total++; if (taken !== 1'b0) begin bad++; $display("FAIL ovf_taken got=%b exp=0", taken); end
    for (int i = 0; i < 4; i++) begin
      do_ret();
      total++; if (counter_out !== exp_ret[i]) begin bad++; $display("FAIL lifo_pc[%0d] got=%h exp=%h", i, counter_out, exp_ret[i]); end
    end
    total++; if (stack_depth_o !== 3'd0) begin bad++; $display("FAIL lifo_depth got=%0d exp=0", stack_depth_o); end
    do_ret();
    total++; if (counter_out !== 8'h20) begin bad++; $display("FAIL unf_pc got=%h exp=20", counter_out); end
    total++; if (stack_underflow !== 1'b1) begin bad++; $display("FAIL unf_flag got=%b exp=1", stack_underflow); end
    total++; if (taken !== 1'b0) begin bad++; $display("FAIL unf_taken got=%b exp=0", taken); end
    do_inc(); step(); do_jump(3'b000, 8'h01);
    total++; if (stack_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", stack_overflow); end
    total++; if (stack_underflow !== 1'b1) begin bad++; $display("FAIL unf_sticky got=%b exp=1", stack_underflow); end
  endtask

  task automatic test_priority_and_reset();
    do_reset();
    do_jump(3'b000, 8'h11);
    do_call(3'b000, 8'h33);
    jump_req = 1'b1; call_req = 1'b1; ret_req = 1'b1; pc_enable = 1'b1;
    cond = 3'b000; target = 8'h44;
    step();
    total++; if (counter_out !== 8'h11) begin bad++; $display("FAIL prio_pc got=%h exp=11", counter_out); end
    total++; if (stack_depth_o !== 3'd0) begin bad++; $display("FAIL prio_depth got=%0d exp=0", stack_depth_o); end
    total++; if (taken !== 1'b1) begin bad++; $display("FAIL prio_taken got=%b exp=1", taken); end
    // set both error flags with a non-empty stack, then reset alongside a call
    do_ret();
    for (int i = 0; i < 5; i++) do_call(3'b000, 8'h60 + 8'(i));
    total++; if ((stack_overflow & stack_underflow) !== 1'b1) begin bad++; $display("FAIL prio_flags_set got=%b%b exp=11", stack_overflow, stack_underflow); end
    reset = 1'b1; call_req = 1'b1; cond = 3'b000; target = 8'h55;
    step();
    total++; if (counter_out !== 8'h00) begin bad++; $display("FAIL rst_call_pc got=%h exp=00", counter_out); end
    total++; if (stack_depth_o !== 3'd0) begin bad++; $display("FAIL rst_call_depth got=%0d exp=0", stack_depth_o); end
    total++; if (stack_overflow !== 1'b0) begin bad++; $display("FAIL rst_call_ovf got=%b exp=0", stack_overflow); end
    total++; if (stack_underflow !== 1'b0) begin bad++; $display("FAIL rst_call_unf got=%b exp=0", stack_underflow); end
    total++; if (taken !== 1'b0) begin bad++; $display("FAIL rst_call_taken got=%b exp=0", taken); end
    do_ret();
    total++; if (stack_underflow !== 1'b1) begin bad++; $display("FAIL rst_discard_unf got=%b exp=1", stack_underflow); end
    total++; if (counter_out !== 8'h00) begin bad++; $display("FAIL rst_discard_pc got=%h exp=00", counter_out); end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    cond = 3'b000; target = 8'h00;
    flag_zero = 1'b0; flag_carry = 1'b0; flag_negative = 1'b0;
    @(negedge clk);
    test_reset();
    test_increment();
    test_wrap();
    test_jump_carry();
    test_cond_sweep();
    test_call_ret();
    test_back_to_back();
    test_overflow_underflow();
    test_priority_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
